// File: rtl/cmd_dispatcher.sv
// UART command dispatcher: decodes command bytes, activates one sub-engine and muxes its TX/memory traffic.
// Optional run watchdog is enabled by defining CMD_DISPATCH_TIMEOUT_EN.
module cmd_dispatcher #(
    parameter int unsigned             NUM_CH         = 5,
    parameter int unsigned             CMD_W          = 8,
    parameter logic [NUM_CH*CMD_W-1:0] CMD_TABLE      = {8'h23, 8'h72, 8'h71, 8'h22, 8'h21},
    parameter int unsigned             DATA_W         = 8,
    parameter int unsigned             ADDR_W         = 8,
    parameter int unsigned             TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CMD_W-1:0]           rx_data,
    input  logic                       rx_ready,
    input  logic                       tx_active,
    output logic [NUM_CH-1:0]          ch_activate,
    input  logic [NUM_CH-1:0]          ch_done,
    input  logic [NUM_CH*DATA_W-1:0]   ch_tx_data,
    input  logic [NUM_CH-1:0]          ch_tx_start,
    output logic [DATA_W-1:0]          tx_data,
    output logic                       tx_start,
    input  logic [NUM_CH-1:0]          ch_mem_we,
    input  logic [NUM_CH-1:0]          ch_mem_clk,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_mem_addr_in,
    input  logic [NUM_CH*DATA_W-1:0]   ch_mem_data_in,
    input  logic [NUM_CH-1:0]          ch_mem_oe,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_mem_addr_out,
    output logic                       mem_we,
    output logic                       mem_clk,
    output logic                       mem_oe,
    output logic [ADDR_W-1:0]          mem_addr_in,
    output logic [ADDR_W-1:0]          mem_addr_out,
    output logic [DATA_W-1:0]          mem_data_in,
    output logic [7:0]                 state_code,
`ifdef CMD_DISPATCH_TIMEOUT_EN
    output logic                       timeout_flag,
`endif
    output logic                       busy,
    output logic [7:0]                 err_cnt
);

    localparam logic [7:0] CODE_IDLE  = 8'h00;
    localparam logic [7:0] CODE_DRAIN = 8'h01;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [NUM_CH-1:0]   act_q, act_d;
    logic [CMD_W-1:0]    cmd_q, cmd_d;
    logic [7:0]          err_q, err_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                tx_start_q, tx_start_d;
    logic [7:0]          code_q, code_d;
    logic                busy_q, busy_d;

    logic                hit_c;
    logic [NUM_CH-1:0]   hit_oh_c;
    logic [DATA_W-1:0]   tx_sel_c;
    logic [7:0]          err_inc_c;

`ifdef CMD_DISPATCH_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0]         to_cnt_q, to_cnt_d;
    logic                to_flag_q, to_flag_d;
`else
    logic                unused_timeout_c;
    assign unused_timeout_c = ^32'(TIMEOUT_CYCLES);
`endif

    // Table lookup; descending scan so the lowest matching index wins.
    always_comb begin
        hit_c    = 1'b0;
        hit_oh_c = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (rx_data == CMD_TABLE[i*CMD_W +: CMD_W]) begin
                hit_c       = 1'b1;
                hit_oh_c    = '0;
                hit_oh_c[i] = 1'b1;
            end
        end
    end

    always_comb begin
        tx_sel_c = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            tx_sel_c = tx_sel_c | (ch_tx_data[i*DATA_W +: DATA_W] & {DATA_W{act_q[i]}});
        end
    end

    assign err_inc_c = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        act_d      = act_q;
        cmd_d      = cmd_q;
        err_d      = err_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
`ifdef CMD_DISPATCH_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
        to_flag_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (rx_ready) begin
                    if (hit_c) begin
                        state_d = S_RUN;
                        act_d   = hit_oh_c;
                        cmd_d   = rx_data;
`ifdef CMD_DISPATCH_TIMEOUT_EN
                        to_cnt_d = '0;
`endif
                    end else begin
                        state_d = S_DRAIN;
                        err_d   = err_inc_c;
                    end
                end
            end
            S_RUN: begin
                tx_data_d  = tx_sel_c;
                tx_start_d = |(ch_tx_start & act_q);
                if (|(ch_done & act_q)) begin
                    state_d = S_DRAIN;
                    act_d   = '0;
                end
`ifdef CMD_DISPATCH_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    state_d   = S_DRAIN;
                    act_d     = '0;
                    err_d     = err_inc_c;
                    to_flag_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 32'd1;
                end
`endif
            end
            S_DRAIN: begin
                if (!rx_ready && !tx_active) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                act_d   = '0;
            end
        endcase

        // Display code and busy track the state being entered so they stay registered.
        case (state_d)
            S_RUN:   code_d = 8'(cmd_d);
            S_DRAIN: code_d = CODE_DRAIN;
            default: code_d = CODE_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            act_q      <= '0;
            cmd_q      <= '0;
            err_q      <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            code_q     <= CODE_IDLE;
            busy_q     <= 1'b0;
`ifdef CMD_DISPATCH_TIMEOUT_EN
            to_cnt_q   <= '0;
            to_flag_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            act_q      <= act_d;
            cmd_q      <= cmd_d;
            err_q      <= err_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            code_q     <= code_d;
            busy_q     <= busy_d;
`ifdef CMD_DISPATCH_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
            to_flag_q  <= to_flag_d;
`endif
        end
    end

    // Shared memory ports: AND-OR of every channel gated by its activate bit.
    always_comb begin
        mem_addr_in  = '0;
        mem_addr_out = '0;
        mem_data_in  = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            mem_addr_in  = mem_addr_in  | (ch_mem_addr_in[i*ADDR_W +: ADDR_W]  & {ADDR_W{act_q[i]}});
            mem_addr_out = mem_addr_out | (ch_mem_addr_out[i*ADDR_W +: ADDR_W] & {ADDR_W{act_q[i]}});
            mem_data_in  = mem_data_in  | (ch_mem_data_in[i*DATA_W +: DATA_W]  & {DATA_W{act_q[i]}});
        end
    end

    assign mem_we      = |(ch_mem_we  & act_q);
    assign mem_clk     = |(ch_mem_clk & act_q);
    assign mem_oe      = |(ch_mem_oe  & act_q);

    assign ch_activate = act_q;
    assign tx_data     = tx_data_q;
    assign tx_start    = tx_start_q;
    assign state_code  = code_q;
    assign busy        = busy_q;
    assign err_cnt     = err_q;
`ifdef CMD_DISPATCH_TIMEOUT_EN
    assign timeout_flag = to_flag_q;
`endif

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Scoreboard bench for cmd_dispatcher: stimulus queues expected values, a negedge monitor compares them.
module tb_cmd_dispatcher;

    localparam int unsigned NUM_CH = 5;
    localparam int unsigned CMD_W  = 8;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 8;
`ifdef CMD_DISPATCH_TIMEOUT_EN
    localparam int unsigned TO_CYC = 100;
`else
    localparam int unsigned TO_CYC = 50_000_000;
`endif

    logic                     clk = 1'b0;
    logic                     reset;
    logic [CMD_W-1:0]         rx_data;
    logic                     rx_ready;
    logic                     tx_active;
    logic [NUM_CH-1:0]        ch_activate;
    logic [NUM_CH-1:0]        ch_done;
    logic [NUM_CH*DATA_W-1:0] ch_tx_data;
    logic [NUM_CH-1:0]        ch_tx_start;
    logic [DATA_W-1:0]        tx_data;
    logic                     tx_start;
    logic [NUM_CH-1:0]        ch_mem_we, ch_mem_clk, ch_mem_oe;
    logic [NUM_CH*ADDR_W-1:0] ch_mem_addr_in, ch_mem_addr_out;
    logic [NUM_CH*DATA_W-1:0] ch_mem_data_in;
    logic                     mem_we, mem_clk, mem_oe;
    logic [ADDR_W-1:0]        mem_addr_in, mem_addr_out;
    logic [DATA_W-1:0]        mem_data_in;
    logic [7:0]               state_code;
    logic                     busy;
    logic [7:0]               err_cnt;
`ifdef CMD_DISPATCH_TIMEOUT_EN
    logic                     timeout_flag;
`endif

    cmd_dispatcher #(
        .NUM_CH(NUM_CH), .CMD_W(CMD_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready), .tx_active(tx_active),
        .ch_activate(ch_activate), .ch_done(ch_done), .ch_tx_data(ch_tx_data), .ch_tx_start(ch_tx_start),
        .tx_data(tx_data), .tx_start(tx_start), .ch_mem_we(ch_mem_we), .ch_mem_clk(ch_mem_clk),
        .ch_mem_addr_in(ch_mem_addr_in), .ch_mem_data_in(ch_mem_data_in), .ch_mem_oe(ch_mem_oe),
        .ch_mem_addr_out(ch_mem_addr_out), .mem_we(mem_we), .mem_clk(mem_clk), .mem_oe(mem_oe),
        .mem_addr_in(mem_addr_in), .mem_addr_out(mem_addr_out), .mem_data_in(mem_data_in),
        .state_code(state_code),
`ifdef CMD_DISPATCH_TIMEOUT_EN
        .timeout_flag(timeout_flag),
`endif
        .busy(busy), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef enum int {
        SG_ACT, SG_CODE, SG_BUSY, SG_ERR, SG_TXDATA, SG_TXSTART, SG_MEMWE, SG_MEMCLK,
        SG_MEMOE, SG_MADDRI, SG_MADDRO, SG_MDATA, SG_TOFLAG
    } sig_e;

    typedef struct {
        int          cyc;
        sig_e        sig;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] tx_q[$];
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] get_sig(sig_e s);
        case (s)
            SG_ACT:     return 32'(ch_activate);
            SG_CODE:    return 32'(state_code);
            SG_BUSY:    return 32'(busy);
            SG_ERR:     return 32'(err_cnt);
            SG_TXDATA:  return 32'(tx_data);
            SG_TXSTART: return 32'(tx_start);
            SG_MEMWE:   return 32'(mem_we);
            SG_MEMCLK:  return 32'(mem_clk);
            SG_MEMOE:   return 32'(mem_oe);
            SG_MADDRI:  return 32'(mem_addr_in);
            SG_MADDRO:  return 32'(mem_addr_out);
            SG_MDATA:   return 32'(mem_data_in);
`ifdef CMD_DISPATCH_TIMEOUT_EN
            SG_TOFLAG:  return 32'(timeout_flag);
`endif
            default:    return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic void chk(int ofs, sig_e s, logic [31:0] v, string nm);
        exp_t e;
        e.cyc  = cyc + ofs;
        e.sig  = s;
        e.val  = v;
        e.name = nm;
        sb_q.push_back(e);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: TX bytes checked whenever tx_start is seen; timed expectations popped per cycle.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        logic [7:0]  eb;
        if (tx_start === 1'b1) begin
            n_tests++;
            if (tx_q.size() == 0) begin
                n_fail++;
                $display("FAIL tx_unexpected: cycle %0d tx_data=%h but no byte expected", cyc, tx_data);
            end else begin
                eb = tx_q.pop_front();
                if (tx_data !== eb) begin
                    n_fail++;
                    $display("FAIL tx_byte: cycle %0d got %h, expected %h", cyc, tx_data, eb);
                end
            end
        end
        while (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
            e   = sb_q.pop_front();
            act = get_sig(e.sig);
            n_tests++;
            if (e.cyc != cyc || act !== e.val) begin
                n_fail++;
                $display("FAIL %s: cycle %0d got %h, expected %h", e.name, e.cyc, act, e.val);
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1'b1; rx_data = '0; rx_ready = 1'b0; tx_active = 1'b0; ch_done = '0;
        ch_tx_data = '0; ch_tx_start = '0; ch_mem_we = '0; ch_mem_clk = '0; ch_mem_oe = '0;
        ch_mem_addr_in = '0; ch_mem_addr_out = '0; ch_mem_data_in = '0;
        tick; tick;
        chk(0, SG_ACT, 0, "rst_act");   chk(0, SG_CODE, 0, "rst_code"); chk(0, SG_BUSY, 0, "rst_busy");
        chk(0, SG_ERR, 0, "rst_err");   chk(0, SG_TXDATA, 0, "rst_txdata");
        chk(0, SG_TXSTART, 0, "rst_txstart"); chk(0, SG_MEMWE, 0, "rst_memwe");
        reset = 1'b0;
        tick;

        // Accept 8'h22 -> channel 1
        rx_data = 8'h22; rx_ready = 1'b1;
        chk(1, SG_ACT, 5'b00010, "act_ch1"); chk(1, SG_CODE, 8'h22, "code_22"); chk(1, SG_BUSY, 1, "busy_run");
        tick; rx_ready = 1'b0; rx_data = '0;

        // TX mux: only the active channel's start reaches uart_tx, one cycle later
        ch_tx_data = 40'h00_5A_00_A5_00; ch_tx_start = 5'b01000;
        chk(1, SG_TXSTART, 0, "tx_other_ch");
        tick; ch_tx_start = 5'b00010;
        chk(1, SG_TXSTART, 1, "tx_start_ch1"); tx_q.push_back(8'hA5);
        tick; ch_tx_start = '0;
        chk(1, SG_TXSTART, 0, "tx_start_drop"); chk(1, SG_TXDATA, 8'hA5, "tx_data_ch1");

        // Done on an inactive channel is ignored, then channel 1 done with TX still busy
        tick; tx_active = 1'b1; ch_done = 5'b00001;
        chk(1, SG_ACT, 5'b00010, "done_inactive_ignored");
        tick; ch_done = 5'b00010;
        chk(1, SG_ACT, 0, "done_ch1_act"); chk(1, SG_CODE, 8'h01, "drain_code"); chk(1, SG_BUSY, 1, "drain_busy");
        tick; ch_done = '0; ch_tx_data = '1;
        for (int k = 0; k < 8; k++) begin
            chk(1, SG_CODE, 8'h01, "drain_wait_tx");
            tick;
        end
        tx_active = 1'b0;
        chk(1, SG_CODE, 8'h00, "drain_exit"); chk(1, SG_BUSY, 0, "idle_busy");
        chk(1, SG_TXDATA, 8'hA5, "tx_data_hold");
        tick; ch_tx_data = '0;

        // rx_ready and ch_done together in IDLE: command wins
        rx_data = 8'h21; rx_ready = 1'b1; ch_done = 5'b00001;
        chk(1, SG_ACT, 5'b00001, "idle_done_ignored"); chk(1, SG_CODE, 8'h21, "code_21");
        tick; rx_ready = 1'b0;
        chk(1, SG_ACT, 0, "ch0_done"); chk(1, SG_CODE, 8'h01, "ch0_drain");
        tick; ch_done = '0;
        chk(1, SG_CODE, 8'h00, "drain_min1");
        tick;

        // Unknown command held for 3 cycles counts once
        rx_data = 8'h55; rx_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk(1, SG_ERR, 1, "err_no_double"); chk(1, SG_ACT, 0, "unknown_no_act");
            chk(1, SG_CODE, 8'h01, "unknown_drain");
            tick;
        end
        rx_ready = 1'b0;
        chk(1, SG_CODE, 8'h00, "drain_after_rx");
        tick;
        for (int k = 2; k <= 300; k++) begin
            rx_ready = 1'b1;
            chk(1, SG_ERR, (k > 255) ? 32'd255 : 32'(k), "err_count");
            tick; rx_ready = 1'b0;
            tick;
        end

        // Memory mux: gated off in IDLE, channel 4 owns the bus while active
        ch_mem_we = 5'b10001; ch_mem_clk = 5'b10001; ch_mem_oe = 5'b00001;
        ch_mem_addr_in = 40'h3C_00_00_00_FF; ch_mem_data_in = 40'h7E_00_00_00_FF;
        ch_mem_addr_out = 40'h11_00_00_00_EE;
        chk(0, SG_MEMWE, 0, "mem_idle_we"); chk(0, SG_MADDRI, 0, "mem_idle_addr"); chk(0, SG_MDATA, 0, "mem_idle_data");
        rx_data = 8'h23; rx_ready = 1'b1;
        chk(1, SG_ACT, 5'b10000, "act_ch4");
        tick; rx_ready = 1'b0;
        chk(0, SG_MEMWE, 1, "mem_we"); chk(0, SG_MADDRI, 8'h3C, "mem_addr_in");
        chk(0, SG_MDATA, 8'h7E, "mem_data_in"); chk(0, SG_MEMCLK, 1, "mem_clk");
        chk(0, SG_MEMOE, 0, "mem_oe_ch0_gated"); chk(0, SG_MADDRO, 8'h11, "mem_addr_out");
        tick; ch_mem_oe = 5'b10001;
        chk(0, SG_MEMOE, 1, "mem_oe_ch4");

        // Reset during RUN
        reset = 1'b1;
        chk(1, SG_ACT, 0, "rst_run_act"); chk(1, SG_CODE, 0, "rst_run_code"); chk(1, SG_BUSY, 0, "rst_run_busy");
        chk(1, SG_ERR, 0, "rst_run_err"); chk(1, SG_TXDATA, 0, "rst_run_txdata"); chk(1, SG_MEMWE, 0, "rst_run_memwe");
        tick; reset = 1'b0;
        ch_mem_we = '0; ch_mem_clk = '0; ch_mem_oe = '0;
        ch_mem_addr_in = '0; ch_mem_data_in = '0; ch_mem_addr_out = '0;
        tick;

        rx_data = 8'h21; rx_ready = 1'b1;
        chk(1, SG_ACT, 5'b00001, "long_run_act");
`ifdef CMD_DISPATCH_TIMEOUT_EN
        chk(100, SG_ACT, 5'b00001, "to_still_active"); chk(100, SG_TOFLAG, 0, "to_flag_low");
        chk(101, SG_ACT, 0, "to_abort"); chk(101, SG_TOFLAG, 1, "to_flag_pulse");
        chk(101, SG_ERR, 1, "to_err"); chk(101, SG_CODE, 8'h01, "to_drain");
        chk(102, SG_TOFLAG, 0, "to_flag_once");
        tick; rx_ready = 1'b0;
        repeat (103) tick;
`else
        chk(200, SG_ACT, 5'b00001, "no_watchdog_hold"); chk(200, SG_ERR, 0, "no_watchdog_err");
        tick; rx_ready = 1'b0;
        repeat (202) tick;
`endif
        n_tests++;
        if (sb_q.size() != 0 || tx_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_queues: %0d expectations and %0d tx bytes left, expected 0", sb_q.size(), tx_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
